uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing one UART transmitter write port (write_en / write_data / full) between NREQ byte-stream requesters. A requester owns the transmitter from grant until it presents its last byte, so packets never interleave on the serial line. The arbiter sits directly in front of the transmitter FIFO and never writes into it while full is high. A watchdog reclaims the port from a requester that stalls mid-packet.

---
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter in front of a UART
// transmitter FIFO write port. The granted requester owns the port until
// its last byte is written or the watchdog reclaims it.
// Optional feature: define UART_ARB_HDR_EN to prefix every packet with a
// one-byte header (ID_BASE + granted index).
module uart_tx_arbiter #(
    parameter int         NREQ    = 2,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] ID_BASE = 8'h30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              abort,
    input  logic              tx_full,
    output logic              tx_write_en,
    output logic [7:0]        tx_write_data
);

    // Index width; a single requester still needs one bit to hold index 0.
    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [15:0]       wd_q, wd_d;
    logic              abort_q, abort_d;

    logic [7:0]        lane_data [NREQ];
    logic [IW-1:0]     g_idx;
    logic [IW-1:0]     ptr_adv;
    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    // Split the flat data bus into one byte per requester lane.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Encode the one-hot grant into the owner index and select its lane.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_idx = IW'(i);
            end
        end
        g_valid = req_valid[g_idx];
        g_last  = req_last[g_idx];
        g_data  = lane_data[g_idx];
        ptr_adv = IW'((int'(g_idx) + 1) % NREQ);
    end

    // Round-robin pick: first valid requester scanning from ptr upward.
    always_comb begin
        logic [IW-1:0] cand;
        cand       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IW'((int'(ptr_q) + off) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state, watchdog and pass-through write logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        wd_d          = wd_q;
        abort_d       = 1'b0;
        req_ready     = '0;
        tx_write_en   = 1'b0;
        tx_write_data = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    wd_d              = '0;
`ifdef UART_ARB_HDR_EN
                    state_d           = S_HDR;
`else
                    state_d           = S_DATA;
`endif
                end
            end

`ifdef UART_ARB_HDR_EN
            S_HDR: begin
                // Header goes out as soon as the FIFO has room.
                if (!tx_full) begin
                    tx_write_en   = 1'b1;
                    tx_write_data = ID_BASE + 8'(g_idx);
                    state_d       = S_DATA;
                end
            end
`endif

            S_DATA: begin
                req_ready[g_idx] = !tx_full;
                if (g_valid && !tx_full) begin
                    // Byte passes straight through to the FIFO this cycle.
                    tx_write_en   = 1'b1;
                    tx_write_data = g_data;
                    wd_d          = '0;
                    if (g_last) begin
                        grant_d = '0;
                        ptr_d   = ptr_adv;
                        state_d = S_IDLE;
                    end
                end else if (!g_valid) begin
                    // Only an owner with nothing to offer ages the watchdog;
                    // a full FIFO with valid held high is not a stall.
                    if (wd_q == WD_LIMIT) begin
                        abort_d = 1'b1;
                        grant_d = '0;
                        ptr_d   = ptr_adv;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        // A cycle with reset asserted must never write or accept a byte.
        if (!rst) begin
            req_ready     = '0;
            tx_write_en   = 1'b0;
            tx_write_data = 8'h00;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);
    assign abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NREQ=2, TIMEOUT=4). Written bytes are
// checked against a scoreboard queue filled in expected service order.
// Honours UART_ARB_HDR_EN when the design is built with the header.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam logic [7:0] IDB = 8'h30;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;
    logic        tx_full;
    logic        tx_write_en;
    logic [7:0]  tx_write_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int write_cnt = 0;
    int abort_cnt = 0;
    int last_write_cyc = 0;
    logic [7:0] sb [$];

    uart_tx_arbiter #(.NREQ(2), .TIMEOUT(4), .ID_BASE(IDB)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy), .abort(abort),
        .tx_full(tx_full), .tx_write_en(tx_write_en), .tx_write_data(tx_write_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (tx_write_en) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_write", {24'h0, tx_write_data}, 32'hFFFF_FFFF);
            end else begin
                check("sb_byte", {24'h0, tx_write_data}, {24'h0, sb.pop_front()});
            end
            check("write_while_full", {31'h0, tx_full}, 32'h0);
            write_cnt++;
            last_write_cyc = cyc;
        end
        if (abort) abort_cnt++;
    end

    // Expected written bytes for one (possibly truncated) packet.
    task automatic push_pkt(input int r, input int n_send, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] b [4];
        b = '{d0, d1, d2, d3};
        if (HDR != 0) sb.push_back(IDB + 8'(r));
        for (int k = 0; k < n_send; k++) sb.push_back(b[k]);
    endtask

    // Requester driver: presents bytes on lane r; stops after n_send bytes
    // (a packet of n bytes is abandoned if n_send < n). Call at posedge+1.
    task automatic send_pkt(input int r, input int n, input int n_send,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [1:0] exp_g,
                            output int st, output int first_c, output int last_c);
        logic [7:0] b [4];
        logic acc;
        int waited;
        b = '{d0, d1, d2, d3};
        st = cyc;
        first_c = 0;
        last_c = 0;
        for (int k = 0; k < n_send; k++) begin
            req_data[8*r +: 8] = b[k];
            req_last[r] = (k == n - 1);
            req_valid[r] = 1'b1;
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < 300) begin
                @(negedge clk);
                if (req_ready[r]) begin
                    acc = 1'b1;
                    if (k == 0) begin
                        first_c = cyc;
                        check($sformatf("grant_req%0d", r), {30'h0, grant}, {30'h0, exp_g});
                    end
                    last_c = cyc;
                end
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                check($sformatf("accept_timeout_req%0d", r), 32'h0, 32'h1);
                k = n_send;
            end
        end
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    typedef struct {
        int         r;
        int         n;
        logic [7:0] d [4];
        logic [1:0] exp_grant;
        int         exp_writes;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int s0, f0, l0, s1, f1, l1, w0, a0;
        logic seen;

        vecs[0] = '{0, 3, '{8'h51, 8'h55, 8'h51, 8'h00}, 2'b01, 3 + HDR};
        vecs[1] = '{1, 1, '{8'hAA, 8'h00, 8'h00, 8'h00}, 2'b10, 1 + HDR};
        vecs[2] = '{0, 1, '{8'h3C, 8'h00, 8'h00, 8'h00}, 2'b01, 1 + HDR};
        vecs[3] = '{1, 4, '{8'h01, 8'h02, 8'h03, 8'h04}, 2'b10, 4 + HDR};
        vecs[4] = '{0, 2, '{8'hE0, 8'h0F, 8'h00, 8'h00}, 2'b01, 2 + HDR};

        rst = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_full = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_abort", {31'h0, abort}, 32'h0);
        check("rst_ready", {30'h0, req_ready}, 32'h0);
        check("rst_write_en", {31'h0, tx_write_en}, 32'h0);
        check("rst_write_data", {24'h0, tx_write_data}, 32'h0);
        $display("reset: outputs idle");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Contention from reset: ptr=0 so req0 first, req1 after a dead cycle
        push_pkt(0, 2, 8'hA0, 8'hA1, 8'h00, 8'h00);
        push_pkt(1, 2, 8'hB0, 8'hB1, 8'h00, 8'h00);
        fork
            send_pkt(0, 2, 2, 8'hA0, 8'hA1, 8'h00, 8'h00, 2'b01, s0, f0, l0);
            send_pkt(1, 2, 2, 8'hB0, 8'hB1, 8'h00, 8'h00, 2'b10, s1, f1, l1);
        join
        check("rr1_gap", f1 - l0, 2 + HDR);
        $display("contention 1: req0 last @%0d, req1 first @%0d", l0, f1);

        // Table-driven single packets from an idle arbiter
        for (int v = 0; v < 5; v++) begin
            w0 = write_cnt;
            push_pkt(vecs[v].r, vecs[v].n, vecs[v].d[0], vecs[v].d[1], vecs[v].d[2], vecs[v].d[3]);
            send_pkt(vecs[v].r, vecs[v].n, vecs[v].n, vecs[v].d[0], vecs[v].d[1], vecs[v].d[2],
                     vecs[v].d[3], vecs[v].exp_grant, s0, f0, l0);
            check("vec_latency", f0 - s0, 1 + HDR);
            check("vec_back_to_back", l0 - f0, vecs[v].n - 1);
            @(negedge clk);
            check("vec_grant_after", {30'h0, grant}, 32'h0);
            check("vec_busy_after", {31'h0, busy}, 32'h0);
            check("vec_write_count", write_cnt - w0, vecs[v].exp_writes);
            $display("vec %0d: req%0d %0d bytes, grant first byte @%0d last @%0d",
                     v, vecs[v].r, vecs[v].n, f0, l0);
            @(posedge clk);
            #1;
        end

        // Contention after req0's packet (ptr=1): req1 must win this time
        push_pkt(1, 2, 8'hD0, 8'hD1, 8'h00, 8'h00);
        push_pkt(0, 2, 8'hC0, 8'hC1, 8'h00, 8'h00);
        fork
            send_pkt(0, 2, 2, 8'hC0, 8'hC1, 8'h00, 8'h00, 2'b01, s0, f0, l0);
            send_pkt(1, 2, 2, 8'hD0, 8'hD1, 8'h00, 8'h00, 2'b10, s1, f1, l1);
        join
        check("rr2_gap", f0 - l1, 2 + HDR);
        $display("contention 2: req1 last @%0d, req0 first @%0d", l1, f0);

        // Backpressure: tx_full high for 5 cycles mid-packet
        w0 = write_cnt;
        a0 = abort_cnt;
        push_pkt(0, 3, 8'h11, 8'h22, 8'h33, 8'h00);
        fork
            send_pkt(0, 3, 3, 8'h11, 8'h22, 8'h33, 8'h00, 2'b01, s0, f0, l0);
            begin
                repeat (2) @(posedge clk);
                #1;
                tx_full = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_ready_low", {30'h0, req_ready}, 32'h0);
                    check("bp_no_write", {31'h0, tx_write_en}, 32'h0);
                    @(posedge clk);
                    #1;
                end
                tx_full = 1'b0;
            end
        join
        check("bp_write_count", write_cnt - w0, 3 + HDR);
        check("bp_no_abort", abort_cnt - a0, 0);
        $display("backpressure: packet done @%0d", l0);

        // Watchdog: req0 stalls after one byte, req1 waits behind it
        a0 = abort_cnt;
        push_pkt(0, 1, 8'h77, 8'h00, 8'h00, 8'h00);
        push_pkt(1, 1, 8'h88, 8'h00, 8'h00, 8'h00);
        fork
            send_pkt(0, 3, 1, 8'h77, 8'h78, 8'h79, 8'h00, 2'b01, s0, f0, l0);
            begin
                repeat (3) @(posedge clk);
                #1;
                send_pkt(1, 1, 1, 8'h88, 8'h00, 8'h00, 8'h00, 2'b10, s1, f1, l1);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    if (abort) begin
                        seen = 1'b1;
                        check("wd_abort_delay", cyc - last_write_cyc, 5);
                        check("wd_grant_at_abort", {30'h0, grant}, 32'h0);
                        @(negedge clk);
                        check("wd_next_grant", {30'h0, grant}, 32'h2);
                        check("wd_abort_one_cycle", {31'h0, abort}, 32'h0);
                    end
                end
                if (!seen) check("wd_abort_seen", 32'h0, 32'h1);
            end
        join
        check("wd_abort_count", abort_cnt - a0, 1);
        $display("watchdog: req0 stalled after @%0d, req1 served @%0d", l0, f1);

        // Reset low for one cycle during the 2nd byte of a 4-byte packet
        push_pkt(0, 1, 8'h91, 8'h00, 8'h00, 8'h00);
        req_data[7:0] = 8'h91;
        req_last[0] = 1'b0;
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = req_ready[0];
            @(posedge clk);
            #1;
        end
        if (!seen) check("rstmid_first_byte", 32'h0, 32'h1);
        req_data[7:0] = 8'h92;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_no_write", {31'h0, tx_write_en}, 32'h0);
        check("rstmid_ready_low", {30'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("rstmid_grant", {30'h0, grant}, 32'h0);
        check("rstmid_busy", {31'h0, busy}, 32'h0);
        check("rstmid_abort", {31'h0, abort}, 32'h0);
        check("rstmid_write_en", {31'h0, tx_write_en}, 32'h0);
        check("rstmid_write_data", {24'h0, tx_write_data}, 32'h0);
        $display("reset mid-packet: outputs idle");
        @(posedge clk);
        #1;

        // Fresh request after reset is granted normally
        push_pkt(1, 2, 8'hF1, 8'hF2, 8'h00, 8'h00);
        send_pkt(1, 2, 2, 8'hF1, 8'hF2, 8'h00, 8'h00, 2'b10, s1, f1, l1);
        check("post_rst_latency", f1 - s1, 1 + HDR);
        $display("post-reset: req1 packet @%0d..%0d", f1, l1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("abort_total", abort_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
